// File: rtl/irq_controller_pkg.sv
// Shared register map, write-lane helper and constants for the interrupt controller.
package irq_controller_pkg;

  typedef enum logic [1:0] {
    REG_PEND = 2'd0,
    REG_MASK = 2'd1,
    REG_MODE = 2'd2,
    REG_VEC  = 2'd3
  } reg_sel_e;

  localparam int VALID_BIT = 31;
  localparam int IDX_W     = 5;

  // Expand the 4 byte enables into a 32-bit per-bit write mask.
  function automatic logic [31:0] be_to_bits(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/irq_prio_arb.sv
// Combinational priority encoder: lowest index wins, or with rotate set the search
// starts just after last_ack and wraps.
module irq_prio_arb
  import irq_controller_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0] active,
  input  logic [4:0]       last_ack,
  input  logic             rotate,
  output logic [4:0]       idx,
  output logic             valid
);

  // Pick the set bit with the smallest circular distance from the search start.
  always_comb begin
    int start_v;
    int dist_v;
    int best_v;
    logic hit_v;
    idx     = 5'd0;
    valid   = 1'b0;
    start_v = rotate ? (int'(last_ack) + 1) : 0;
    start_v = (start_v >= N_SRC) ? 0 : start_v;
    best_v  = N_SRC;
    dist_v  = 0;
    hit_v   = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      dist_v = i - start_v;
      dist_v = (dist_v < 0) ? (dist_v + N_SRC) : dist_v;
      hit_v  = active[i] && (dist_v < best_v);
      best_v = hit_v ? dist_v : best_v;
      idx    = hit_v ? 5'(i) : idx;
      valid  = valid | hit_v;
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Programmable interrupt controller: latches, masks and prioritises device lines,
// exposes PEND/MASK/MODE/VEC through a 4-word window and drives a registered IRQ.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int N_SRC  = 8,
  parameter int ROTATE = 0
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [1:0]       Addr,
  input  logic             Wr,
  input  logic [3:0]       BE,
  input  logic [31:0]      WD,
  output logic [31:0]      RD,
  input  logic [N_SRC-1:0] irq_src,
  output logic             IRQ
);

  reg_sel_e         sel_s;
  logic [31:0]      be_bits_s;
  logic [N_SRC-1:0] lane_s;
  logic [N_SRC-1:0] wd_s;
  logic             wr_pend_s;
  logic             wr_mask_s;
  logic             wr_mode_s;
  logic             wr_vec_s;

  logic [N_SRC-1:0] pend_r;
  logic [N_SRC-1:0] mask_r;
  logic [N_SRC-1:0] mode_r;
  logic [N_SRC-1:0] src_q_r;
  logic [4:0]       last_ack_r;
  logic             irq_r;

  logic [N_SRC-1:0] active_s;
  logic [4:0]       arb_idx_s;
  logic             arb_valid_s;
  logic [N_SRC-1:0] set_s;
  logic [N_SRC-1:0] clr_s;
  logic [N_SRC-1:0] ack_bit_s;
  logic [N_SRC-1:0] pend_next_s;
  logic [N_SRC-1:0] mask_next_s;
  logic [N_SRC-1:0] mode_next_s;
  logic             unused_ok_s;

  assign sel_s     = reg_sel_e'(Addr);
  assign be_bits_s = be_to_bits(BE);
  assign lane_s    = be_bits_s[N_SRC-1:0];
  assign wd_s      = WD[N_SRC-1:0];
  assign wr_pend_s = Wr && (sel_s == REG_PEND);
  assign wr_mask_s = Wr && (sel_s == REG_MASK);
  assign wr_mode_s = Wr && (sel_s == REG_MODE);
  assign wr_vec_s  = Wr && (sel_s == REG_VEC);

  // Write-data bits above N_SRC and their lanes are intentionally dropped.
  assign unused_ok_s = ^{WD, be_bits_s};

  assign active_s = pend_r & mask_r;

  irq_prio_arb #(
    .N_SRC(N_SRC)
  ) u_arb (
    .active  (active_s),
    .last_ack(last_ack_r),
    .rotate  (ROTATE != 0),
    .idx     (arb_idx_s),
    .valid   (arb_valid_s)
  );

  // Edge sources merge new edges with surviving bits (set beats clr); level
  // sources simply follow the line, so W1C and ACK have no effect on them.
  always_comb begin
    set_s       = irq_src & ~src_q_r;
    ack_bit_s   = (wr_vec_s && arb_valid_s) ? (N_SRC'(1) << arb_idx_s) : '0;
    clr_s       = (wr_pend_s ? (wd_s & lane_s) : '0) | ack_bit_s;
    pend_next_s = (mode_r & (set_s | (pend_r & ~clr_s))) | (~mode_r & irq_src);
    mask_next_s = wr_mask_s ? ((mask_r & ~lane_s) | (wd_s & lane_s)) : mask_r;
    mode_next_s = wr_mode_s ? ((mode_r & ~lane_s) | (wd_s & lane_s)) : mode_r;
  end

  // Controller state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!RST) begin
      pend_r     <= '0;
      mask_r     <= '0;
      mode_r     <= '0;
      src_q_r    <= '0;
      last_ack_r <= 5'(N_SRC - 1);
      irq_r      <= 1'b0;
    end else begin
      pend_r  <= pend_next_s;
      mask_r  <= mask_next_s;
      mode_r  <= mode_next_s;
      src_q_r <= irq_src;
      irq_r   <= |active_s;
      if (wr_vec_s && arb_valid_s) begin
        last_ack_r <= arb_idx_s;
      end
    end
  end

  assign IRQ = irq_r;

  // Side-effect-free read mux.
  always_comb begin
    RD = 32'd0;
    case (sel_s)
      REG_PEND: RD = 32'(pend_r);
      REG_MASK: RD = 32'(mask_r);
      REG_MODE: RD = 32'(mode_r);
      REG_VEC: begin
        RD            = 32'(arb_idx_s);
        RD[VALID_BIT] = arb_valid_s;
      end
      default:  RD = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench: a fixed-priority and a round-robin controller share one stimulus stream.
module tb_irq_controller;

  logic        clk;
  logic        RST;
  logic [1:0]  Addr;
  logic        Wr;
  logic [3:0]  BE;
  logic [31:0] WD;
  logic [7:0]  irq_src;
  logic [31:0] rd_fix;
  logic [31:0] rd_rr;
  logic        irq_fix;
  logic        irq_rr;

  int n_checks;
  int n_fail;

  irq_controller #(.N_SRC(8), .ROTATE(0)) u_fix (
    .clk(clk), .RST(RST), .Addr(Addr), .Wr(Wr), .BE(BE), .WD(WD),
    .RD(rd_fix), .irq_src(irq_src), .IRQ(irq_fix)
  );

  irq_controller #(.N_SRC(8), .ROTATE(1)) u_rr (
    .clk(clk), .RST(RST), .Addr(Addr), .Wr(Wr), .BE(BE), .WD(WD),
    .RD(rd_rr), .irq_src(irq_src), .IRQ(irq_rr)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
    Addr = a;
    BE   = be;
    WD   = d;
    Wr   = 1'b1;
    tick();
    Wr   = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a,
                        input logic [31:0] exp_fix, input logic [31:0] exp_rr);
    Addr = a;
    #1;
    chk_eq({tag, "_fix"}, rd_fix, exp_fix);
    chk_eq({tag, "_rr"}, rd_rr, exp_rr);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST      = 1'b0;
    Addr     = 2'd0;
    Wr       = 1'b0;
    BE       = 4'h0;
    WD       = 32'd0;
    irq_src  = 8'hFF;

    // Reset with all lines high
    tick();
    tick();
    rd_chk("rst_pend", 2'd0, 32'd0, 32'd0);
    rd_chk("rst_mask", 2'd1, 32'd0, 32'd0);
    rd_chk("rst_mode", 2'd2, 32'd0, 32'd0);
    rd_chk("rst_vec",  2'd3, 32'd0, 32'd0);
    chk_eq("rst_irq", {31'd0, irq_fix}, 32'd0);
    irq_src = 8'h00;
    RST     = 1'b1;
    tick();

    // Edge source 0: latency and ACK
    wr(2'd2, 4'hF, 32'h0000_0001);
    wr(2'd1, 4'hF, 32'h0000_0001);
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    rd_chk("edge_pend", 2'd0, 32'h1, 32'h1);
    chk_eq("edge_irq_t", {31'd0, irq_fix}, 32'd0);
    tick();
    chk_eq("edge_irq_t1", {31'd0, irq_fix}, 32'd1);
    rd_chk("edge_vec", 2'd3, 32'h8000_0000, 32'h8000_0000);
    wr(2'd3, 4'hF, 32'd0);
    rd_chk("ack_pend", 2'd0, 32'h0, 32'h0);
    tick();
    chk_eq("ack_irq", {31'd0, irq_fix}, 32'd0);

    // Fixed priority: sources 5 and 2 together
    wr(2'd2, 4'hF, 32'h0000_00FF);
    wr(2'd1, 4'hF, 32'h0000_00FF);
    irq_src = 8'h24;
    tick();
    irq_src = 8'h00;
    rd_chk("prio_vec0", 2'd3, 32'h8000_0002, 32'h8000_0002);
    wr(2'd3, 4'hF, 32'd0);
    rd_chk("prio_vec1", 2'd3, 32'h8000_0005, 32'h8000_0005);
    wr(2'd3, 4'hF, 32'd0);
    rd_chk("prio_vec2", 2'd3, 32'h0, 32'h0);
    tick();
    chk_eq("prio_irq", {31'd0, irq_fix}, 32'd0);
    chk_eq("prio_irq_rr", {31'd0, irq_rr}, 32'd0);
    wr(2'd3, 4'hF, 32'd0);
    rd_chk("ack_invalid", 2'd3, 32'h0, 32'h0);

    // Round-robin: sources 1 and 3, ACK 1, re-pulse 1
    irq_src = 8'h0A;
    tick();
    irq_src = 8'h00;
    rd_chk("rr_vec0", 2'd3, 32'h8000_0001, 32'h8000_0001);
    wr(2'd3, 4'hF, 32'd0);
    irq_src = 8'h02;
    tick();
    irq_src = 8'h00;
    rd_chk("rr_vec1", 2'd3, 32'h8000_0001, 32'h8000_0003);
    wr(2'd3, 4'hF, 32'd0);
    rd_chk("rr_vec2", 2'd3, 32'h8000_0003, 32'h8000_0001);
    wr(2'd0, 4'hF, 32'h0000_00FF);
    rd_chk("rr_clear", 2'd0, 32'h0, 32'h0);

    // Level mode with mask
    wr(2'd2, 4'hF, 32'd0);
    wr(2'd1, 4'hF, 32'd0);
    irq_src = 8'h10;
    tick();
    rd_chk("lvl_pend", 2'd0, 32'h10, 32'h10);
    tick();
    chk_eq("lvl_irq_masked", {31'd0, irq_fix}, 32'd0);
    wr(2'd1, 4'hF, 32'h0000_0010);
    tick();
    chk_eq("lvl_irq_on", {31'd0, irq_fix}, 32'd1);
    wr(2'd0, 4'hF, 32'h0000_00FF);
    rd_chk("lvl_w1c", 2'd0, 32'h10, 32'h10);
    irq_src = 8'h00;
    tick();
    rd_chk("lvl_drop", 2'd0, 32'h0, 32'h0);
    tick();
    chk_eq("lvl_irq_off", {31'd0, irq_fix}, 32'd0);

    // Collision and byte enables
    wr(2'd2, 4'hF, 32'h0000_0001);
    wr(2'd1, 4'hF, 32'h0000_0001);
    irq_src = 8'h01;
    wr(2'd0, 4'hF, 32'h0000_0001);
    irq_src = 8'h00;
    rd_chk("coll_pend", 2'd0, 32'h1, 32'h1);
    wr(2'd1, 4'b0010, 32'hFFFF_FFFF);
    rd_chk("be_mask", 2'd1, 32'h1, 32'h1);
    wr(2'd0, 4'b0010, 32'h0000_00FF);
    rd_chk("be_w1c_off", 2'd0, 32'h1, 32'h1);
    wr(2'd0, 4'b0001, 32'h0000_00FF);
    rd_chk("be_w1c_on", 2'd0, 32'h0, 32'h0);
    wr(2'd1, 4'hF, 32'hFFFF_FFFF);
    rd_chk("mask_width", 2'd1, 32'h0000_00FF, 32'h0000_00FF);
    rd_chk("mode_keep", 2'd2, 32'h1, 32'h1);

    // Reset mid-operation, level line held high
    wr(2'd2, 4'hF, 32'd0);
    irq_src = 8'h10;
    tick();
    rd_chk("mid_pend", 2'd0, 32'h10, 32'h10);
    RST = 1'b0;
    tick();
    rd_chk("mid_rst_pend", 2'd0, 32'h0, 32'h0);
    rd_chk("mid_rst_mask", 2'd1, 32'h0, 32'h0);
    chk_eq("mid_rst_irq", {31'd0, irq_fix}, 32'd0);
    RST = 1'b1;
    tick();
    rd_chk("relatch", 2'd0, 32'h10, 32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
